// File: rtl/weight_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : weight_fetch_ctrl
// Brief    : Streams a contiguous run of weights out of the weight RAM using
//            N-word burst reads, one weight per valid/ready transfer.
// Revision : 1.0 - initial release
// ============================================================================
module weight_fetch_ctrl #(
    parameter int N     = 10,
    parameter int W     = 10,
    parameter int AW    = 7,
    parameter int DEPTH = 65
) (
    input  logic            Clock,
    input  logic            Rst,
    input  logic            Start,
    input  logic [AW-1:0]   BaseAddr,
    input  logic [AW-1:0]   Count,
    output logic            Busy,
    output logic            Done,
    output logic            Err,
    output logic [AW-1:0]   Address,
    output logic            WE,
    input  logic [N*W-1:0]  Q,
    output logic [W-1:0]    WOut,
    output logic            WValid,
    input  logic            WReady,
    output logic [AW-1:0]   WIndex
);

    localparam int              c_PW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0]   c_MAXA   = AW'(DEPTH - N);
    localparam logic [AW-1:0]   c_NW     = AW'(N);
    localparam logic [AW:0]     c_DEPTHX = (AW+1)'(DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ    = 3'd1;
    localparam logic [2:0] S_CAP    = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [AW-1:0]   r_next;
    logic [AW-1:0]   r_rem;
    logic [AW-1:0]   r_len;
    logic [AW-1:0]   r_cnt;
    logic [c_PW-1:0] r_off;
    logic [c_PW-1:0] r_ptr;
    logic [AW-1:0]   r_addr;
    logic [AW-1:0]   r_index;
    logic            r_err;
    logic [W-1:0]    r_buf [N];

    logic [AW:0]     w_sum;
    logic            w_bad;
    logic [AW-1:0]   w_a;
    logic [c_PW-1:0] w_off;
    logic [AW-1:0]   w_room;
    logic [AW-1:0]   w_len;
    logic            w_last;

    // Reads are clamped so a whole burst always stays inside the RAM.
    always_comb begin
        w_sum  = {1'b0, BaseAddr} + {1'b0, Count};
        w_bad  = (Count == '0) || (w_sum > c_DEPTHX);
        w_a    = (r_next > c_MAXA) ? c_MAXA : r_next;
        w_off  = c_PW'(r_next - w_a);
        w_room = c_NW - AW'(w_off);
        w_len  = (r_rem < w_room) ? r_rem : w_room;
        w_last = (r_cnt == (r_len - 1'b1));
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (Start && !w_bad) w_state_nxt = S_REQ;
            S_REQ:    w_state_nxt = S_CAP;
            S_CAP:    w_state_nxt = S_STREAM;
            S_STREAM: begin
                if (WReady && w_last) begin
                    w_state_nxt = (r_rem == AW'(1)) ? S_DONE : S_REQ;
                end
            end
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            r_next  <= '0;
            r_rem   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_off   <= '0;
            r_ptr   <= '0;
            r_addr  <= '0;
            r_index <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        if (w_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_next  <= BaseAddr;
                            r_rem   <= Count;
                            r_index <= '0;
                        end
                    end
                end
                S_REQ: begin
                    r_addr <= w_a;
                    r_off  <= w_off;
                    r_len  <= w_len;
                end
                S_CAP: begin
                    r_ptr <= r_off;
                    r_cnt <= '0;
                end
                S_STREAM: begin
                    if (WReady) begin
                        r_ptr   <= r_ptr + 1'b1;
                        r_index <= r_index + 1'b1;
                        r_rem   <= r_rem - 1'b1;
                        r_cnt   <= r_cnt + 1'b1;
                        if (w_last) r_next <= r_next + r_len;
                    end
                end
                default: ;
            endcase
        end
    end

    // Burst buffer carries no reset; it is only read after a capture.
    always_ff @(posedge Clock) begin
        if (r_state == S_CAP) begin
            for (int k = 0; k < N; k++) begin
                r_buf[k] <= Q[k*W +: W];
            end
        end
    end

    always_comb begin
        Busy    = (r_state == S_REQ) || (r_state == S_CAP) || (r_state == S_STREAM);
        Done    = (r_state == S_DONE);
        Err     = r_err;
        WE      = 1'b0;
        WValid  = (r_state == S_STREAM);
        WOut    = (r_state == S_STREAM) ? r_buf[r_ptr] : '0;
        WIndex  = r_index;
        Address = (r_state == S_REQ) ? w_a : r_addr;
    end

endmodule
`default_nettype wire

// File: tb/tb_weight_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_weight_fetch_ctrl
// Brief    : Self-checking bench for weight_fetch_ctrl with a RAM model and a
//            run-level reference model of the expected weight stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_weight_fetch_ctrl;

    localparam int N     = 10;
    localparam int W     = 10;
    localparam int AW    = 7;
    localparam int DEPTH = 65;

    logic            Clock = 1'b0;
    logic            Rst;
    logic            Start;
    logic [AW-1:0]   BaseAddr;
    logic [AW-1:0]   Count;
    logic            Busy;
    logic            Done;
    logic            Err;
    logic [AW-1:0]   Address;
    logic            WE;
    logic [N*W-1:0]  Q;
    logic [W-1:0]    WOut;
    logic            WValid;
    logic            WReady;
    logic [AW-1:0]   WIndex;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] mem [DEPTH];
    bit pat [$];

    weight_fetch_ctrl #(.N(N), .W(W), .AW(AW), .DEPTH(DEPTH)) dut (
        .Clock(Clock), .Rst(Rst), .Start(Start), .BaseAddr(BaseAddr), .Count(Count),
        .Busy(Busy), .Done(Done), .Err(Err), .Address(Address), .WE(WE), .Q(Q),
        .WOut(WOut), .WValid(WValid), .WReady(WReady), .WIndex(WIndex)
    );

    always #5 Clock = ~Clock;

    initial begin
        for (int k = 0; k < DEPTH; k++) mem[k] = W'(k + 100);
    end

    // Registered-read RAM: data for Address appears one edge later.
    always @(posedge Clock) begin
        for (int k = 0; k < N; k++) begin
            Q[k*W +: W] <= ((int'(Address) + k) < DEPTH) ? mem[int'(Address) + k] : '0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // rmode: 0 = always ready, 1 = random ready, 2 = ready from pat queue
    task automatic run(input int base, input int cnt, input int rmode, input bit poke);
        int chunks [$];
        int addrs [$];
        int nxt, rem, a, l, i, ci, left, bubble, cyc, pk;
        bit r, fin;
        nxt = base;
        rem = cnt;
        while (rem > 0) begin
            a = (nxt > DEPTH - N) ? DEPTH - N : nxt;
            l = N - (nxt - a);
            if (rem < l) l = rem;
            chunks.push_back(l);
            addrs.push_back(a);
            nxt += l;
            rem -= l;
        end
        @(negedge Clock);
        BaseAddr = AW'(base);
        Count    = AW'(cnt);
        Start    = 1'b1;
        WReady   = 1'b0;
        @(negedge Clock);
        Start  = 1'b0;
        i = 0; ci = 0; left = chunks[0]; bubble = 2; fin = 1'b0; cyc = 0; pk = 0;
        while (!fin && cyc < 40 * cnt + 40) begin
            chk("busy", 32'(Busy), 1);
            chk("done_low", 32'(Done), 0);
            chk("err_low", 32'(Err), 0);
            chk("we", 32'(WE), 0);
            if (bubble > 0) begin
                chk("gap_valid", 32'(WValid), 0);
                if (bubble == 2) chk("req_addr", 32'(Address), addrs[ci]);
                bubble--;
                WReady = 1'($urandom_range(0, 1));
            end else begin
                chk("valid", 32'(WValid), 1);
                chk("wout", 32'(WOut), 32'(mem[base + i]));
                chk("windex", 32'(WIndex), i);
                case (rmode)
                    0:       r = 1'b1;
                    1:       r = 1'($urandom_range(0, 1));
                    default: r = (pk < pat.size()) ? pat[pk] : 1'b1;
                endcase
                pk++;
                WReady = r;
                if (r) begin
                    i++;
                    left--;
                    if (left == 0) begin
                        ci++;
                        if (ci < chunks.size()) begin
                            left   = chunks[ci];
                            bubble = 2;
                        end else begin
                            fin = 1'b1;
                        end
                    end
                end
            end
            Start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            if (Start) begin
                BaseAddr = AW'($urandom_range(0, 127));
                Count    = AW'($urandom_range(0, 127));
            end
            @(negedge Clock);
            cyc++;
        end
        Start = 1'b0;
        if (!fin) begin
            tests++;
            fails++;
            $error("FAIL timeout: observed %0d words expected %0d", i, cnt);
        end else begin
            chk("done", 32'(Done), 1);
            chk("done_busy", 32'(Busy), 0);
            chk("done_valid", 32'(WValid), 0);
            chk("done_err", 32'(Err), 0);
            @(negedge Clock);
            chk("done_pulse", 32'(Done), 0);
            chk("idle_busy", 32'(Busy), 0);
            chk("idle_err", 32'(Err), 0);
            chk("addr_hold", 32'(Address), addrs[addrs.size() - 1]);
        end
    endtask

    task automatic reject(input int base, input int cnt);
        logic [AW-1:0] a0;
        @(negedge Clock);
        a0       = Address;
        BaseAddr = AW'(base);
        Count    = AW'(cnt);
        Start    = 1'b1;
        WReady   = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        chk("rej_err", 32'(Err), 1);
        chk("rej_busy", 32'(Busy), 0);
        chk("rej_addr", 32'(Address), 32'(a0));
        chk("rej_valid", 32'(WValid), 0);
        @(negedge Clock);
        chk("rej_err_pulse", 32'(Err), 0);
        chk("rej_busy2", 32'(Busy), 0);
        chk("rej_addr2", 32'(Address), 32'(a0));
    endtask

    task automatic chk_reset_vals();
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_done", 32'(Done), 0);
        chk("rst_err", 32'(Err), 0);
        chk("rst_addr", 32'(Address), 0);
        chk("rst_we", 32'(WE), 0);
        chk("rst_valid", 32'(WValid), 0);
        chk("rst_wout", 32'(WOut), 0);
        chk("rst_windex", 32'(WIndex), 0);
    endtask

    initial begin
        int b, c;
        Rst = 1'b1; Start = 1'b0; BaseAddr = '0; Count = '0; WReady = 1'b0;
        repeat (2) @(negedge Clock);
        chk_reset_vals();
        Rst = 1'b0;

        run(0, 10, 0, 1'b0);
        run(5, 23, 0, 1'b0);
        run(60, 5, 0, 1'b0);
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        run(0, 4, 2, 1'b0);
        reject(60, 6);
        reject(7, 0);
        reject(64, 2);
        run(55, 10, 1, 1'b1);

        // Reset lands on the third streaming cycle of a 10-word run.
        @(negedge Clock);
        BaseAddr = '0; Count = AW'(10); Start = 1'b1; WReady = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        repeat (4) @(negedge Clock);
        Rst = 1'b1;
        @(negedge Clock);
        Rst = 1'b0;
        chk_reset_vals();
        run(20, 2, 0, 1'b0);

        for (int t = 0; t < 8; t++) begin
            b = int'($urandom_range(0, DEPTH - 1));
            c = int'($urandom_range(1, DEPTH - b));
            run(b, c, 1, 1'b1);
        end
        for (int t = 0; t < 3; t++) begin
            b = int'($urandom_range(0, DEPTH - 1));
            reject(b, DEPTH - b + int'($urandom_range(1, 5)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
